calc_sequencer: RTL and testbench

- Parametrised successor of the board calculator's operand/operation control: sequences entry of NUM_OPERANDS operands, each with its own latched add/sub operation, into a signed accumulator, then presents a saturated signed result.
- Sits between calculator_input (debounced pulses) and slider_increment/display; replaces the free-running select counter and unreachable display states with an explicit FSM.
- Adds behaviour not present before: N-operand chaining, sign output, overflow saturation, result re-use, clear.

---
 rtl/calc_pkg.sv | 17 +
 rtl/calc_saturate.sv | 26 ++
 rtl/calc_sequencer.sv | 157 +++++++++++++++
 tb/tb_calc_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and defaults for the calculator operand/operation sequencer.
package calc_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    typedef enum logic {
        ST_ENTRY  = 1'b0,
        ST_RESULT = 1'b1
    } state_t;

    // Largest magnitude a four-digit display can show.
    localparam int CALC_MAX_VALUE = 9999;

endpackage

// File: rtl/calc_saturate.sv
// Signed accumulator -> display magnitude, sign and overflow flag.
// Magnitudes above MAX_VALUE are clamped to MAX_VALUE and flagged.
module calc_saturate
    import calc_pkg::*;
#(
    parameter int WIDTH     = 14,
    parameter int ACC_W     = 16,
    parameter int MAX_VALUE = CALC_MAX_VALUE
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [WIDTH-1:0] magnitude,
    output logic                    negative,
    output logic                    overflow
);

    logic [ACC_W-1:0] abs_val;

    // Absolute value then clamp; the accumulator is sized so -acc never wraps.
    always_comb begin
        negative  = acc[ACC_W-1];
        abs_val   = negative ? $unsigned(-acc) : $unsigned(acc);
        overflow  = abs_val > ACC_W'(MAX_VALUE);
        magnitude = overflow ? WIDTH'(MAX_VALUE) : abs_val[WIDTH-1:0];
    end

endmodule

// File: rtl/calc_sequencer.sv
// Operand/operation sequencer: collects NUM_OPERANDS operands, each combined
// with its own latched add/sub, into a signed accumulator and presents a
// saturated signed result. Supports chaining from a result and clear.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH        = 14,
    parameter int NUM_OPERANDS = 2,
    parameter int MAX_VALUE    = CALC_MAX_VALUE
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clr_pulse,
    input  logic                            add_pulse,
    input  logic                            sub_pulse,
    input  logic                            ent_pulse,
    input  logic [WIDTH-1:0]                operand_in,
    output logic                            operand_clear,
    output logic [$clog2(NUM_OPERANDS)-1:0] operand_index,
    output logic                            result_valid,
    output logic [WIDTH-1:0]                display_value,
    output logic                            display_negative,
    output logic                            overflow,
    output logic                            pending_sub
);

    localparam int IDX_W = $clog2(NUM_OPERANDS);
    localparam int ACC_W = WIDTH + IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPERANDS - 1);

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    op_t                      pend_q, pend_d;
    logic                     clear_q, clear_d;
    logic [WIDTH-1:0]         disp_q, disp_d;
    logic                     neg_q, neg_d;
    logic                     ovf_q, ovf_d;

    logic [WIDTH-1:0]         operand_c;
    logic signed [ACC_W-1:0]  operand_ext;
    logic [WIDTH-1:0]         sat_mag;
    logic                     sat_neg;
    logic                     sat_ovf;

    // Clamp the live slider value before it is displayed or accumulated.
    always_comb begin
        operand_c   = (operand_in > WIDTH'(MAX_VALUE)) ? WIDTH'(MAX_VALUE) : operand_in;
        operand_ext = $signed({{(ACC_W-WIDTH){1'b0}}, operand_c});
    end

    // Saturate the next accumulator value so the result shows on the same
    // cycle result_valid rises.
    calc_saturate #(
        .WIDTH     (WIDTH),
        .ACC_W     (ACC_W),
        .MAX_VALUE (MAX_VALUE)
    ) u_sat (
        .acc       (acc_d),
        .magnitude (sat_mag),
        .negative  (sat_neg),
        .overflow  (sat_ovf)
    );

    // Next-state, accumulator and display logic; priority clr > ent > add/sub.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        pend_d  = pend_q;
        clear_d = 1'b0;

        if (clr_pulse) begin
            state_d = ST_ENTRY;
            idx_d   = '0;
            acc_d   = '0;
            pend_d  = OP_ADD;
            clear_d = 1'b1;
        end else begin
            if (ent_pulse) begin
                clear_d = 1'b1;
                case (state_q)
                    ST_ENTRY: begin
                        if (idx_q == '0)
                            acc_d = operand_ext;
                        else if (pend_q == OP_SUB)
                            acc_d = acc_q - operand_ext;
                        else
                            acc_d = acc_q + operand_ext;
                        pend_d = OP_ADD;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_RESULT;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                    // Chain: the result stays in acc as operand 0; the pending
                    // op chosen while viewing the result is kept.
                    ST_RESULT: begin
                        state_d = ST_ENTRY;
                        idx_d   = IDX_W'(1);
                    end
                    default: state_d = ST_ENTRY;
                endcase
            end
            // Same-cycle add/sub targets the next operand, so it overrides
            // the post-commit reset to ADD.
            if (sub_pulse)
                pend_d = OP_SUB;
            else if (add_pulse)
                pend_d = OP_ADD;
        end

        if (state_d == ST_RESULT) begin
            disp_d = sat_mag;
            neg_d  = sat_neg;
            ovf_d  = sat_ovf;
        end else begin
            disp_d = operand_c;
            neg_d  = 1'b0;
            ovf_d  = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ENTRY;
            idx_q   <= '0;
            acc_q   <= '0;
            pend_q  <= OP_ADD;
            clear_q <= 1'b0;
            disp_q  <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            pend_q  <= pend_d;
            clear_q <= clear_d;
            disp_q  <= disp_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign operand_clear    = clear_q;
    assign operand_index    = idx_q;
    assign result_valid     = (state_q == ST_RESULT);
    assign display_value    = disp_q;
    assign display_negative = neg_q;
    assign overflow         = ovf_q;
    assign pending_sub      = (pend_q == OP_SUB);

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: table-driven two-operand vectors checked through
// a result scoreboard, plus hand-written corner-case sequences and a
// three-operand instance.
module tb_calc_sequencer;

    localparam int WIDTH = 14;

    logic clk = 1'b0;
    logic reset = 1'b0;

    // Two-operand instance
    logic             clr_pulse = 0, add_pulse = 0, sub_pulse = 0, ent_pulse = 0;
    logic [WIDTH-1:0] operand_in = '0;
    logic             operand_clear, result_valid, display_negative, overflow, pending_sub;
    logic [0:0]       operand_index;
    logic [WIDTH-1:0] display_value;

    // Three-operand instance
    logic             c3_clr = 0, c3_add = 0, c3_sub = 0, c3_ent = 0;
    logic [WIDTH-1:0] c3_operand = '0;
    logic             c3_oclear, c3_valid, c3_neg, c3_ovf, c3_psub;
    logic [1:0]       c3_index;
    logic [WIDTH-1:0] c3_disp;

    int errors = 0;
    int checks = 0;
    int clr_cnt = 0;
    logic rv_prev = 1'b0;

    typedef struct {
        int disp;
        int neg;
        int ovf;
    } res_t;
    res_t sb[$];

    typedef struct {
        int a;
        bit sub;
        int b;
        int disp;
        bit neg;
        bit ovf;
    } vec_t;
    vec_t vecs[7];

    calc_sequencer #(.WIDTH(WIDTH), .NUM_OPERANDS(2), .MAX_VALUE(9999)) u_dut (
        .clk              (clk),
        .reset            (reset),
        .clr_pulse        (clr_pulse),
        .add_pulse        (add_pulse),
        .sub_pulse        (sub_pulse),
        .ent_pulse        (ent_pulse),
        .operand_in       (operand_in),
        .operand_clear    (operand_clear),
        .operand_index    (operand_index),
        .result_valid     (result_valid),
        .display_value    (display_value),
        .display_negative (display_negative),
        .overflow         (overflow),
        .pending_sub      (pending_sub)
    );

    calc_sequencer #(.WIDTH(WIDTH), .NUM_OPERANDS(3), .MAX_VALUE(9999)) u_dut3 (
        .clk              (clk),
        .reset            (reset),
        .clr_pulse        (c3_clr),
        .add_pulse        (c3_add),
        .sub_pulse        (c3_sub),
        .ent_pulse        (c3_ent),
        .operand_in       (c3_operand),
        .operand_clear    (c3_oclear),
        .operand_index    (c3_index),
        .result_valid     (c3_valid),
        .display_value    (c3_disp),
        .display_negative (c3_neg),
        .overflow         (c3_ovf),
        .pending_sub      (c3_psub)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ent();
        ent_pulse = 1; step(); ent_pulse = 0;
    endtask

    task automatic do_add();
        add_pulse = 1; step(); add_pulse = 0;
    endtask

    task automatic do_sub();
        sub_pulse = 1; step(); sub_pulse = 0;
    endtask

    task automatic do_clr();
        clr_pulse = 1; step(); clr_pulse = 0;
    endtask

    // Scoreboard: every rising result_valid pops one expected result.
    always @(negedge clk) begin
        if (reset && operand_clear) clr_cnt++;
        if (reset && result_valid && !rv_prev) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_result", display_value, -1);
            end else begin
                res_t e;
                e = sb.pop_front();
                chk("sb_display", display_value, e.disp);
                chk("sb_negative", display_negative, e.neg);
                chk("sb_overflow", overflow, e.ovf);
            end
        end
        rv_prev = result_valid;
    end

    initial begin
        vecs[0] = '{1234, 1'b1, 34, 1200, 1'b0, 1'b0};
        vecs[1] = '{12, 1'b1, 100, 88, 1'b1, 1'b0};
        vecs[2] = '{9000, 1'b0, 2000, 9999, 1'b0, 1'b1};
        vecs[3] = '{500, 1'b0, 250, 750, 1'b0, 1'b0};
        vecs[4] = '{0, 1'b1, 9999, 9999, 1'b1, 1'b0};
        vecs[5] = '{12000, 1'b0, 12000, 9999, 1'b0, 1'b1};
        vecs[6] = '{5, 1'b1, 5, 0, 1'b0, 1'b0};

        // Reset held with pulses active
        reset = 0;
        ent_pulse = 1; add_pulse = 1; sub_pulse = 1; operand_in = 42;
        c3_ent = 1; c3_operand = 42;
        repeat (3) step();
        chk("rst_display", display_value, 0);
        chk("rst_index", operand_index, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_clear", operand_clear, 0);
        chk("rst_pending_sub", pending_sub, 0);
        chk("rst_neg_ovf", {display_negative, overflow}, 0);
        chk("rst3_index_disp", c3_index + c3_disp, 0);
        ent_pulse = 0; add_pulse = 0; sub_pulse = 0; c3_ent = 0;
        reset = 1;
        step();
        chk("entry_latency_42", display_value, 42);
        chk("entry_clear_idle", operand_clear, 0);

        // Live operand clamp in ENTRY
        operand_in = 12000; step();
        chk("entry_clamp_12000", display_value, 9999);
        chk("entry_clamp_ovf", overflow, 0);
        operand_in = 9999; step();
        chk("entry_9999", display_value, 9999);
        operand_in = 10000; step();
        chk("entry_clamp_10000", display_value, 9999);

        // Table-driven two-operand vectors
        for (int i = 0; i < 7; i++) begin
            do_clr(); step();
            clr_cnt = 0;
            operand_in = WIDTH'(vecs[i].a);
            do_ent();
            chk($sformatf("v%0d_index1", i), operand_index, 1);
            if (vecs[i].sub) do_sub(); else do_add();
            chk($sformatf("v%0d_pending", i), pending_sub, vecs[i].sub);
            operand_in = WIDTH'(vecs[i].b);
            sb.push_back('{vecs[i].disp, vecs[i].neg, vecs[i].ovf});
            do_ent();
            chk($sformatf("v%0d_valid", i), result_valid, 1);
            step();
            chk($sformatf("v%0d_clear_cnt", i), clr_cnt, 2);
            do_clr();
            chk($sformatf("v%0d_clr_valid", i), result_valid, 0);
            chk($sformatf("v%0d_clr_index", i), operand_index, 0);
        end

        // Chaining from a result: 1234 - 34 = 1200, then + 5
        do_clr(); step();
        operand_in = 1234; do_ent();
        do_sub();
        operand_in = 34;
        sb.push_back('{1200, 0, 0});
        do_ent();
        step();
        operand_in = 0;
        do_ent();
        chk("chain_index", operand_index, 1);
        chk("chain_valid_low", result_valid, 0);
        chk("chain_clear", operand_clear, 1);
        do_add();
        operand_in = 5;
        sb.push_back('{1205, 0, 0});
        do_ent();
        chk("chain_valid", result_valid, 1);
        step();

        // add+sub together: sub wins; commit then returns to ADD
        do_clr(); step();
        add_pulse = 1; sub_pulse = 1; step(); add_pulse = 0; sub_pulse = 0;
        chk("addsub_pending", pending_sub, 1);
        operand_in = 3; do_ent();
        chk("ent_resets_pending", pending_sub, 0);

        // sub arriving with ent applies to the next operand: 20 - 5
        do_clr(); step();
        operand_in = 20;
        ent_pulse = 1; sub_pulse = 1; step(); ent_pulse = 0; sub_pulse = 0;
        chk("ent_sub_pending", pending_sub, 1);
        operand_in = 5;
        sb.push_back('{15, 0, 0});
        do_ent();
        step();

        // clr + ent at index 1: clear wins, one clear pulse
        do_clr(); step();
        operand_in = 7; do_ent();
        chk("clrent_pre_index", operand_index, 1);
        clr_pulse = 1; ent_pulse = 1; step(); clr_pulse = 0; ent_pulse = 0;
        chk("clrent_index", operand_index, 0);
        chk("clrent_clear", operand_clear, 1);
        chk("clrent_valid", result_valid, 0);
        step();
        chk("clrent_clear_single", operand_clear, 0);
        chk("clrent_display", display_value, 7);
        // Accumulator was cleared: a fresh 7 + 8 gives 15
        do_ent(); do_add(); operand_in = 8;
        sb.push_back('{15, 0, 0});
        do_ent();
        step();

        // Back-to-back ent pulses give back-to-back clear pulses
        do_clr(); step();
        operand_in = 1;
        ent_pulse = 1; step();
        chk("b2b_clear_1", operand_clear, 1);
        sb.push_back('{2, 0, 0});
        step(); ent_pulse = 0;
        chk("b2b_clear_2", operand_clear, 1);
        step();
        chk("b2b_clear_end", operand_clear, 0);

        // Asynchronous reset mid-entry
        do_clr(); step();
        operand_in = 100; do_ent(); do_sub();
        #2 reset = 0;
        #1;
        chk("midrst_index", operand_index, 0);
        chk("midrst_pending", pending_sub, 0);
        chk("midrst_display", display_value, 0);
        chk("midrst_valid_clear", {result_valid, operand_clear}, 0);
        step();
        reset = 1;
        step();
        chk("midrst_no_clear", operand_clear, 0);
        chk("midrst_display_live", display_value, 100);

        // Three-operand instance: 10 - 3 + 5 = 12
        c3_clr = 1; step(); c3_clr = 0;
        c3_operand = 10; c3_ent = 1; step(); c3_ent = 0;
        chk("n3_index1", c3_index, 1);
        c3_sub = 1; step(); c3_sub = 0;
        c3_operand = 3; c3_ent = 1; step(); c3_ent = 0;
        chk("n3_index2", c3_index, 2);
        chk("n3_not_valid", c3_valid, 0);
        c3_add = 1; step(); c3_add = 0;
        c3_operand = 5; c3_ent = 1; step(); c3_ent = 0;
        chk("n3_valid", c3_valid, 1);
        chk("n3_display", c3_disp, 12);
        chk("n3_negative", c3_neg, 0);

        step();
        chk("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
